// File: rtl/jtag_instruction_register_gen.sv
// JTAG instruction register, second generation.
// Combines the IR shift stage, the update stage and the one-hot opcode decoder.
module jtag_instruction_register_gen #(
  parameter int                IR_LEN          = 4,
  parameter logic [IR_LEN-1:0] OPC_IDCODE      = IR_LEN'(4'b0001),
  parameter logic [IR_LEN-1:0] OPC_SAMPLE      = IR_LEN'(4'b0010),
  parameter logic [IR_LEN-1:0] OPC_EXTEST      = IR_LEN'(4'b0000),
  parameter logic [IR_LEN-1:0] OPC_PROGRAM     = IR_LEN'(4'b0101),
  parameter logic [IR_LEN-1:0] OPC_INTEST      = IR_LEN'(4'b0110),
  parameter bit                IDCODE_AT_RESET = 1'b1
) (
  input  logic              clkIR,
  input  logic              reset,
  input  logic              tlr,
  input  logic              capIR,
  input  logic              shIR,
  input  logic              upIR,
  input  logic              tdi,
  input  logic [IR_LEN-1:0] piData,
  output logic              tdo_mux,
  output logic [5:0]        instrB,
  output logic [IR_LEN-1:0] opcode,
  output logic              instr_changed
);

  localparam logic [IR_LEN-1:0] ALL1   = '1;
  localparam logic [IR_LEN-1:0] SR_RST = IR_LEN'(2'b01);

  localparam logic [IR_LEN-1:0] OPC_RST =
    IDCODE_AT_RESET ? OPC_IDCODE : ALL1;

  localparam logic [5:0] INS_RST =
    IDCODE_AT_RESET ? 6'b000010 : 6'b000001;

  logic [IR_LEN-1:0] sr;
  logic [IR_LEN-1:0] cap_val;
  logic [5:0]        dec;

  // All-ones is BYPASS regardless of the map; otherwise first match wins.
  function automatic logic [5:0] decode(input logic [IR_LEN-1:0] op);
    logic [5:0] d;
    d = 6'b000001;
    if (op == ALL1)             d = 6'b000001;
    else if (op == OPC_IDCODE)  d = 6'b000010;
    else if (op == OPC_SAMPLE)  d = 6'b000100;
    else if (op == OPC_EXTEST)  d = 6'b001000;
    else if (op == OPC_PROGRAM) d = 6'b010000;
    else if (op == OPC_INTEST)  d = 6'b100000;
    return d;
  endfunction

  always_comb begin
    cap_val      = piData;
    cap_val[1:0] = 2'b01;
  end

  assign dec     = decode(sr);
  assign tdo_mux = sr[0];

  always_ff @(posedge clkIR or posedge reset) begin
    if (reset) begin
      sr            <= SR_RST;
      opcode        <= OPC_RST;
      instrB        <= INS_RST;
      instr_changed <= 1'b0;
    end else begin
      instr_changed <= 1'b0;
      if (tlr) begin
        opcode        <= OPC_RST;
        instrB        <= INS_RST;
        instr_changed <= (instrB != INS_RST);
      end else if (capIR) begin
        sr <= cap_val;
      end else if (shIR) begin
        sr <= {tdi, sr[IR_LEN-1:1]};
      end else if (upIR) begin
        opcode        <= sr;
        instrB        <= dec;
        instr_changed <= (dec != instrB);
      end
    end
  end

endmodule

// File: tb/tb_jtag_instruction_register_gen.sv
// Directed bench for jtag_instruction_register_gen.
// Two instances: IDCODE-at-reset (a) and BYPASS-at-reset (b).
module tb_jtag_instruction_register_gen;

  logic       clk;
  logic       reset;
  logic       tlr, capIR, shIR, upIR, tdi;
  logic [3:0] piData;

  logic       tdo_a, chg_a;
  logic [5:0] ins_a;
  logic [3:0] opc_a;
  logic       tdo_b, chg_b;
  logic [5:0] ins_b;
  logic [3:0] opc_b;

  int n_run;
  int n_fail;

  jtag_instruction_register_gen #(.IDCODE_AT_RESET(1'b1)) dut_a (
    .clkIR(clk), .reset(reset), .tlr(tlr), .capIR(capIR),
    .shIR(shIR), .upIR(upIR), .tdi(tdi), .piData(piData),
    .tdo_mux(tdo_a), .instrB(ins_a), .opcode(opc_a),
    .instr_changed(chg_a)
  );

  jtag_instruction_register_gen #(.IDCODE_AT_RESET(1'b0)) dut_b (
    .clkIR(clk), .reset(reset), .tlr(tlr), .capIR(capIR),
    .shIR(shIR), .upIR(upIR), .tdi(tdi), .piData(piData),
    .tdo_mux(tdo_b), .instrB(ins_b), .opcode(opc_b),
    .instr_changed(chg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic t, input logic c, input logic s,
                     input logic u, input logic d);
    tlr = t; capIR = c; shIR = s; upIR = u; tdi = d;
    @(posedge clk);
    #1;
    tlr = 0; capIR = 0; shIR = 0; upIR = 0; tdi = 0;
  endtask

  task automatic shift4(input logic [3:0] v);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, v[i]);
  endtask

  task automatic test_reset();
    reset = 1;
    #12;
    reset = 0;
    @(posedge clk);
    #1;
    n_run++;
    if (ins_a !== 6'b000010) begin
      n_fail++;
      $display("FAIL rst_instrB_a got %b want 000010", ins_a);
    end
    n_run++;
    if (opc_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_opcode_a got %b want 0001", opc_a);
    end
    n_run++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_chg_a got %b want 0", chg_a);
    end
    n_run++;
    if (ins_b !== 6'b000001) begin
      n_fail++;
      $display("FAIL rst_instrB_b got %b want 000001", ins_b);
    end
    n_run++;
    if (opc_b !== 4'b1111) begin
      n_fail++;
      $display("FAIL rst_opcode_b got %b want 1111", opc_b);
    end
    n_run++;
    if (tdo_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_sr_lsb got %b want 1", tdo_a);
    end
  endtask

  task automatic test_capture_shift();
    logic [3:0] e;
    e = 4'b1001;
    piData = 4'b1010;
    cyc(0, 1, 0, 0, 0);
    piData = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (tdo_a !== e[i]) begin
        n_fail++;
        $display("FAIL cap_tdo[%0d] got %b want %b", i, tdo_a, e[i]);
      end
      cyc(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_update_program();
    shift4(4'b0101);
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (ins_a !== 6'b010000) begin
      n_fail++;
      $display("FAIL prog_instrB got %b want 010000", ins_a);
    end
    n_run++;
    if (opc_a !== 4'b0101) begin
      n_fail++;
      $display("FAIL prog_opcode got %b want 0101", opc_a);
    end
    n_run++;
    if (chg_a !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_chg got %b want 1", chg_a);
    end
    cyc(0, 0, 0, 0, 0);
    n_run++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_chg_drop got %b want 0", chg_a);
    end
    n_run++;
    if (ins_a !== 6'b010000) begin
      n_fail++;
      $display("FAIL prog_hold got %b want 010000", ins_a);
    end
  endtask

  task automatic test_bypass_unmapped();
    shift4(4'b1111);
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (ins_a !== 6'b000001) begin
      n_fail++;
      $display("FAIL byp_instrB got %b want 000001", ins_a);
    end
    n_run++;
    if (chg_a !== 1'b1) begin
      n_fail++;
      $display("FAIL byp_chg got %b want 1", chg_a);
    end
    shift4(4'b1001);
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (ins_a !== 6'b000001) begin
      n_fail++;
      $display("FAIL unm_instrB got %b want 000001", ins_a);
    end
    n_run++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL unm_chg got %b want 0", chg_a);
    end
    n_run++;
    if (opc_a !== 4'b1001) begin
      n_fail++;
      $display("FAIL unm_opcode got %b want 1001", opc_a);
    end
  endtask

  task automatic test_tlr_priority();
    shift4(4'b0110);
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (ins_a !== 6'b100000) begin
      n_fail++;
      $display("FAIL intest_instrB got %b want 100000", ins_a);
    end
    piData = 4'b1110;
    cyc(1, 1, 0, 1, 0);
    piData = 4'b0000;
    n_run++;
    if (ins_a !== 6'b000010) begin
      n_fail++;
      $display("FAIL tlr_instrB got %b want 000010", ins_a);
    end
    n_run++;
    if (opc_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL tlr_opcode got %b want 0001", opc_a);
    end
    n_run++;
    if (chg_a !== 1'b1) begin
      n_fail++;
      $display("FAIL tlr_chg got %b want 1", chg_a);
    end
    n_run++;
    if (tdo_a !== 1'b0) begin
      n_fail++;
      $display("FAIL tlr_sr_kept got %b want 0", tdo_a);
    end
    n_run++;
    if (ins_b !== 6'b000001) begin
      n_fail++;
      $display("FAIL tlr_instrB_b got %b want 000001", ins_b);
    end
    cyc(0, 0, 0, 0, 0);
    n_run++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL tlr_chg_drop got %b want 0", chg_a);
    end
  endtask

  task automatic test_long_shift();
    logic [7:0] p;
    p = 8'b10110010;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 0, p[k]);
      if (k >= 3) begin
        n_run++;
        if (tdo_a !== p[k-3]) begin
          n_fail++;
          $display("FAIL long_tdo[%0d] got %b want %b", k, tdo_a, p[k-3]);
        end
      end
    end
    n_run++;
    if (opc_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL long_opcode_hold got %b want 0001", opc_a);
    end
  endtask

  task automatic test_reset_mid_shift();
    shift4(4'b0010);
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (ins_a !== 6'b000100) begin
      n_fail++;
      $display("FAIL sample_instrB got %b want 000100", ins_a);
    end
    piData = 4'b1100;
    cyc(0, 1, 0, 0, 0);
    piData = 4'b0000;
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    #2;
    reset = 1;
    #1;
    n_run++;
    if (ins_a !== 6'b000010) begin
      n_fail++;
      $display("FAIL async_instrB got %b want 000010", ins_a);
    end
    #2;
    reset = 0;
    cyc(0, 0, 0, 1, 0);
    n_run++;
    if (opc_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_opcode got %b want 0001", opc_a);
    end
    n_run++;
    if (ins_a !== 6'b000010) begin
      n_fail++;
      $display("FAIL mid_instrB got %b want 000010", ins_a);
    end
    n_run++;
    if (chg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_chg got %b want 0", chg_a);
    end
    n_run++;
    if (ins_b !== 6'b000010) begin
      n_fail++;
      $display("FAIL mid_instrB_b got %b want 000010", ins_b);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset  = 1;
    tlr    = 0;
    capIR  = 0;
    shIR   = 0;
    upIR   = 0;
    tdi    = 0;
    piData = 4'b0000;
    test_reset();
    test_capture_shift();
    test_update_program();
    test_bypass_unmapped();
    test_tlr_priority();
    test_long_shift();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
